// File: rtl/cpu_pkg.sv
// Core-wide constants and types shared by fetch, imem and the trap unit.
package cpu_pkg;

    localparam logic [3:0]  EXC_INSTR_MISALIGNED   = 4'd0;
    localparam logic [3:0]  EXC_INSTR_ACCESS_FAULT = 4'd1;
    localparam logic [31:0] NOP_INSTR              = 32'h0000_0013;
    localparam logic [63:0] DEFAULT_RESET_PC       = 64'h0000_0000_0000_0000;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [31:0] instr;
        logic        exc_en;
        logic [3:0]  exc_code;
        logic [63:0] exc_val;
    } fetch_pkt_t;

endpackage

// File: rtl/ifetch_unit.sv
// Instruction fetch: PC register, one-entry output stage, fault parking.
// Optional IFETCH_PERF_EN adds saturating transfer/stall counters.
module ifetch_unit
    import cpu_pkg::*;
#(
    parameter logic [63:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          XLEN     = 64
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] pc_addr,
    input  logic [31:0]     imem_instr,
    input  logic            imem_exc_en,
    input  logic [3:0]      imem_exc_code,
    input  logic [XLEN-1:0] imem_exc_val,
    input  logic            redirect_en,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_instr,
    output logic            out_exc_en,
    output logic [3:0]      out_exc_code,
    output logic [XLEN-1:0] out_exc_val
`ifdef IFETCH_PERF_EN
    ,
    output logic [63:0]     perf_fetched,
    output logic [63:0]     perf_stall
`endif
);

    fetch_state_e state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    fetch_pkt_t pkt_q, pkt_d;
    logic capture;

    assign capture = (state_q == RUN) && !redirect_en && (!pkt_q.valid || out_ready);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pkt_d   = pkt_q;
        if (redirect_en) begin
            // Flush wins over a same-cycle handshake; the held packet is dropped.
            state_d     = RUN;
            pc_d        = redirect_pc;
            pkt_d.valid = 1'b0;
        end else if (capture) begin
            pkt_d.valid = 1'b1;
            pkt_d.pc    = pc_q;
            if (pc_q[1:0] != 2'b00) begin
                pkt_d.instr    = NOP_INSTR;
                pkt_d.exc_en   = 1'b1;
                pkt_d.exc_code = EXC_INSTR_MISALIGNED;
                pkt_d.exc_val  = pc_q;
                state_d        = FAULT;
            end else if (imem_exc_en) begin
                pkt_d.instr    = NOP_INSTR;
                pkt_d.exc_en   = 1'b1;
                pkt_d.exc_code = imem_exc_code;
                pkt_d.exc_val  = imem_exc_val;
                state_d        = FAULT;
            end else begin
                pkt_d.instr    = imem_instr;
                pkt_d.exc_en   = 1'b0;
                pkt_d.exc_code = 4'd0;
                pkt_d.exc_val  = '0;
                pc_d           = pc_q + XLEN'(4);
            end
        end else if (pkt_q.valid && out_ready) begin
            pkt_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= RUN;
            pc_q           <= RESET_PC;
            pkt_q.valid    <= 1'b0;
            pkt_q.pc       <= '0;
            pkt_q.instr    <= NOP_INSTR;
            pkt_q.exc_en   <= 1'b0;
            pkt_q.exc_code <= 4'd0;
            pkt_q.exc_val  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pkt_q   <= pkt_d;
        end
    end

    assign pc_addr      = pc_q;
    assign out_valid    = pkt_q.valid;
    assign out_pc       = pkt_q.pc;
    assign out_instr    = pkt_q.instr;
    assign out_exc_en   = pkt_q.exc_en;
    assign out_exc_code = pkt_q.exc_code;
    assign out_exc_val  = pkt_q.exc_val;

`ifdef IFETCH_PERF_EN
    logic [63:0] fetched_q, stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetched_q <= '0;
            stall_q   <= '0;
        end else begin
            if (pkt_q.valid && out_ready && !redirect_en && (fetched_q != '1))
                fetched_q <= fetched_q + 64'd1;
            if (pkt_q.valid && !out_ready && (stall_q != '1))
                stall_q <= stall_q + 64'd1;
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_stall   = stall_q;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed scenarios plus random traffic
// compared every cycle against a packet-level reference model.
module tb_ifetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] pc_addr;
    logic [31:0] imem_instr;
    logic        imem_exc_en;
    logic [3:0]  imem_exc_code;
    logic [63:0] imem_exc_val;
    logic        redirect_en;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        out_exc_en;
    logic [3:0]  out_exc_code;
    logic [63:0] out_exc_val;
`ifdef IFETCH_PERF_EN
    logic [63:0] perf_fetched, perf_stall;
`endif

    always #5 clk = ~clk;

    ifetch_unit dut (
        .clk(clk), .rst(rst), .pc_addr(pc_addr),
        .imem_instr(imem_instr), .imem_exc_en(imem_exc_en),
        .imem_exc_code(imem_exc_code), .imem_exc_val(imem_exc_val),
        .redirect_en(redirect_en), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_instr(out_instr), .out_exc_en(out_exc_en),
        .out_exc_code(out_exc_code), .out_exc_val(out_exc_val)
`ifdef IFETCH_PERF_EN
        , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference model: a fetch pointer, a "parked" flag and at most one held packet.
    typedef struct {
        bit          v;
        logic [63:0] pc;
        logic [31:0] instr;
        bit          exc;
        logic [3:0]  code;
        logic [63:0] val;
    } pkt_t;

    logic [63:0] m_pc;
    bit          m_parked;
    pkt_t        m_pkt;
    longint unsigned m_fetched, m_stall;

    function automatic pkt_t reset_pkt();
        pkt_t p;
        p.v = 0; p.pc = 0; p.instr = NOP; p.exc = 0; p.code = 0; p.val = 0;
        return p;
    endfunction

    task automatic model_step();
        bit xfer;
        if (rst) begin
            m_pc = 64'h0; m_parked = 0; m_pkt = reset_pkt();
            m_fetched = 0; m_stall = 0;
            return;
        end
        if (m_pkt.v && !out_ready) m_stall++;
        if (redirect_en) begin
            m_pc = redirect_pc; m_parked = 0; m_pkt.v = 0;
            return;
        end
        xfer = m_pkt.v && out_ready;
        if (xfer) m_fetched++;
        if (!m_pkt.v || xfer) begin
            m_pkt.v = 0;
            if (!m_parked) begin
                m_pkt.v = 1; m_pkt.pc = m_pc;
                if (m_pc % 4 != 0) begin
                    m_pkt.instr = NOP; m_pkt.exc = 1; m_pkt.code = 0; m_pkt.val = m_pc;
                    m_parked = 1;
                end else if (imem_exc_en) begin
                    m_pkt.instr = NOP; m_pkt.exc = 1; m_pkt.code = imem_exc_code;
                    m_pkt.val = imem_exc_val; m_parked = 1;
                end else begin
                    m_pkt.instr = imem_instr; m_pkt.exc = 0; m_pkt.code = 0; m_pkt.val = 0;
                    m_pc = m_pc + 64'd4;
                end
            end
        end
    endtask

    task automatic check_all(input string ph);
        chk({ph, ".pc_addr"},  pc_addr,      m_pc);
        chk({ph, ".valid"},    out_valid,    m_pkt.v);
        chk({ph, ".out_pc"},   out_pc,       m_pkt.pc);
        chk({ph, ".instr"},    out_instr,    m_pkt.instr);
        chk({ph, ".exc_en"},   out_exc_en,   m_pkt.exc);
        chk({ph, ".exc_code"}, out_exc_code, m_pkt.code);
        chk({ph, ".exc_val"},  out_exc_val,  m_pkt.val);
`ifdef IFETCH_PERF_EN
        chk({ph, ".perf_fetched"}, perf_fetched, m_fetched);
        chk({ph, ".perf_stall"},   perf_stall,   m_stall);
`endif
    endtask

    // Drive one cycle of inputs (called after a negedge), clock, then check.
    task automatic cyc(input string ph, input bit r, input bit red, input logic [63:0] rpc,
                       input bit rdy, input logic [31:0] ins, input bit ex = 0,
                       input logic [3:0] code = 0, input logic [63:0] val = 0);
        rst = r; redirect_en = red; redirect_pc = rpc; out_ready = rdy;
        imem_instr = ins; imem_exc_en = ex; imem_exc_code = code; imem_exc_val = val;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all(ph);
    endtask

    logic [31:0] prog [4] = '{32'h0000_0093, 32'h0010_0113, 32'h0020_0193, 32'h0030_0213};

    initial begin
        rst = 1; redirect_en = 0; redirect_pc = 0; out_ready = 1;
        imem_instr = 0; imem_exc_en = 0; imem_exc_code = 0; imem_exc_val = 0;
        m_pc = 0; m_parked = 0; m_pkt = reset_pkt(); m_fetched = 0; m_stall = 0;
        @(negedge clk);
        cyc("reset", 1, 0, 0, 1, 0);
        chk("reset.instr_nop", out_instr, NOP);
        chk("reset.pc0", pc_addr, 64'h0);

        // Straight-line fetch: PC 0,4,8,12 with matching instructions.
        for (int i = 0; i < 4; i++) begin
            cyc("seq", 0, 0, 0, 1, prog[i]);
            chk("seq.pc_const", out_pc, 64'(i * 4));
            chk("seq.instr_const", out_instr, prog[i]);
        end

        // Backpressure with a packet held, then release.
        cyc("bp_pre", 1, 0, 0, 1, 0);
        cyc("bp_a", 0, 0, 0, 1, prog[0]);
        cyc("bp_b", 0, 0, 0, 1, prog[1]);
        cyc("bp_c", 0, 0, 0, 1, prog[2]);
        for (int i = 0; i < 3; i++) begin
            cyc("bp_hold", 0, 0, 0, 0, 32'hdead_beef);
            chk("bp.out_pc8", out_pc, 64'h8);
            chk("bp.pc_addr12", pc_addr, 64'hC);
        end
        cyc("bp_rel", 0, 0, 0, 1, prog[3]);
        chk("bp.next12", out_pc, 64'hC);

        // Redirect while a packet is valid and ready is high.
        cyc("rd_a", 0, 0, 0, 1, 32'h1);
        cyc("rd_flush", 0, 1, 64'h100, 1, 32'h2);
        chk("rd.valid0", out_valid, 1'b0);
        chk("rd.pc100", pc_addr, 64'h100);
        cyc("rd_b", 0, 0, 0, 1, 32'h3);
        chk("rd.out_pc100", out_pc, 64'h100);

        // Misaligned target parks the unit.
        cyc("mis_rd", 0, 1, 64'h102, 1, 0);
        cyc("mis_pkt", 0, 0, 0, 0, 32'h5, 1, 4'd1, 64'h999);
        chk("mis.code0", out_exc_code, 4'd0);
        chk("mis.val", out_exc_val, 64'h102);
        cyc("mis_acc", 0, 0, 0, 1, 32'h5);
        for (int i = 0; i < 3; i++) cyc("mis_park", 0, 0, 0, 1, 32'h6, 1, 4'd1, 64'h7);
        chk("mis.parked_pc", pc_addr, 64'h102);
        chk("mis.parked_valid", out_valid, 1'b0);

        // Imem access fault, then recovery via redirect to 0.
        cyc("af_rd", 0, 1, 64'h40000, 1, 0);
        cyc("af_pkt", 0, 0, 0, 1, 32'h7, 1, 4'd1, 64'h40000);
        chk("af.code1", out_exc_code, 4'd1);
        chk("af.instr_nop", out_instr, NOP);
        cyc("af_idle", 0, 0, 0, 1, 32'h8);
        cyc("af_rec", 0, 1, 64'h0, 1, 32'h8);
        cyc("af_run", 0, 0, 0, 1, 32'h9);
        chk("af.resume", out_instr, 32'h9);

        // PC wraps modulo 2^64.
        cyc("wrap_rd", 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 0);
        cyc("wrap_a", 0, 0, 0, 1, 32'hA);
        chk("wrap.pc0", pc_addr, 64'h0);

        // Reset while parked with an undrained fault packet.
        cyc("rm_rd", 0, 1, 64'h3, 0, 0);
        cyc("rm_pkt", 0, 0, 0, 0, 0);
        cyc("rm_hold", 0, 0, 0, 0, 0);
        cyc("rm_rst", 1, 0, 0, 0, 0);
        chk("rm.valid0", out_valid, 1'b0);
        cyc("rm_run", 0, 0, 0, 1, 32'hB);
        chk("rm.running", out_instr, 32'hB);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            bit r, red, rdy, ex;
            logic [63:0] rpc;
            r   = ($urandom_range(0, 199) == 0);
            red = ($urandom_range(0, 19) == 0);
            rpc = {$urandom(), $urandom()};
            if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
            rdy = ($urandom_range(0, 9) < 7);
            ex  = ($urandom_range(0, 29) == 0);
            cyc("rand", r, red, rpc, rdy, $urandom(), ex, 4'($urandom()), {$urandom(), $urandom()});
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
Instruction-fetch initiator that drives the instruction memory. It owns the PC register, presents the PC to imem, and registers the returned word or fault into a one-entry output stage. That stage feeds decode through a valid/ready handshake. Branch and trap redirects come from later stages; after a fetch fault the unit parks until a redirect arrives.

Parameters:
RESET_PC, 64'h0000_0000_0000_0000, PC loaded on reset
XLEN, 64, address/PC width (fixed at 64 in this core)

Ports:
clk  input  1  core clock
rst  input  1  synchronous active-high reset
pc_addr  output  64  fetch address to imem, combinational copy of PC register
imem_instr  input  32  instruction word from imem
imem_exc_en  input  1  imem access fault flag
imem_exc_code  input  4  imem fault cause
imem_exc_val  input  64  imem fault address (MTVAL)
redirect_en  input  1  flush and load new PC
redirect_pc  input  64  redirect target
out_valid  output  1  output stage holds a fetch packet
out_ready  input  1  decode accepts packet
out_pc  output  64  PC of packet
out_instr  output  32  instruction, NOP 32'h00000013 on fault
out_exc_en  output  1  packet carries fetch exception
out_exc_code  output  4  cause (0 misaligned, 1 access fault)
out_exc_val  output  64  MTVAL for the fault

Behaviour:
- Reset (rst=1 at posedge):
  - PC=RESET_PC; state=RUN.
  - out_valid=0, out_pc=0, out_instr=32'h00000013, out_exc_en=0, out_exc_code=0, out_exc_val=0.
  - rst mid-operation discards any held packet and any FAULT state.
- States:
  - RUN: fetching.
  - FAULT: a fault packet has been issued; no further fetch until redirect.
- Priority per cycle: rst > redirect_en > capture.
- Redirect: PC<=redirect_pc, out_valid<=0 (flushes the held packet even if out_ready=1 that cycle, so no transfer counts), state<=RUN. No capture in the redirect cycle.
- Capture condition: state==RUN && !redirect_en && (!out_valid || out_ready).
  - Normal capture: out_* <= {1, PC, imem_instr, 0, 0, 0}; PC<=PC+4, wrapping mod 2^64.
  - Misaligned (PC[1:0]!=0): emit fault packet with code 0, val=PC, instr=NOP; state<=FAULT; PC holds. Takes precedence over imem_exc_en.
  - imem_exc_en=1: emit fault packet with imem_exc_code and imem_exc_val, instr=NOP; state<=FAULT; PC holds.
- Hold: out_valid && !out_ready means all out_* stable and PC stable.
- FAULT: the packet drains on out_ready, then out_valid=0. Idle until redirect_en.
- Latency: PC presented in cycle N gives a packet valid in cycle N+1. Throughput is 1 per cycle while out_ready=1.
- imem_exc_en is sampled only in capture cycles; imem's internal fault toggling does not re-trigger a fault outside capture.

Optional Feature:
- Macro: IFETCH_PERF_EN
- Defined:
  - Adds outputs perf_fetched (64) and perf_stall (64).
  - perf_fetched counts packets transferred (out_valid && out_ready, excluding redirect cycles).
  - perf_stall counts cycles with out_valid && !out_ready.
  - Both reset to 0 on rst and saturate at all-ones.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package cpu_pkg holds:
  - EXC_INSTR_MISALIGNED=4'd0 and EXC_INSTR_ACCESS_FAULT=4'd1, shared with imem and the trap unit.
  - NOP_INSTR=32'h00000013.
  - Default RESET_PC.
  - Fetch-state enum {RUN, FAULT}.
- No sub-module. The output stage is one register bank, and a separate skid buffer is unnecessary because redirect flushes it.

Test Plan:
- Reset, RESET_PC=0, out_ready=1, imem returns 0x00000093/0x00100113/... for 4 cycles -> out_pc=0,4,8,12 on consecutive cycles, out_instr matches, out_exc_en=0.
- Backpressure: out_ready=0 for 3 cycles at out_pc=8 -> out_* and pc_addr frozen at 8/12; on release, next packet is out_pc=12 with no loss or duplicate.
- Redirect: redirect_en=1 with redirect_pc=0x100 while out_valid=1 at pc 0x10 -> next cycle out_valid=0, pc_addr=0x100; the cycle after, out_pc=0x100.
- Misaligned: redirect_pc=0x102 -> packet out_exc_en=1, out_exc_code=0, out_exc_val=0x102, out_instr=0x00000013; after acceptance out_valid=0 and pc_addr stays 0x102 until redirect.
- Access fault: imem_exc_en=1, imem_exc_code=1, imem_exc_val=0x40000 at PC 0x40000 -> fault packet code 1, val 0x40000; a later redirect to 0 resumes normal fetch.
- Reset mid-stall: out_valid=1, out_ready=0, state FAULT, then rst pulse -> out_valid=0, pc_addr=RESET_PC, state RUN; with IFETCH_PERF_EN defined, both counters are 0.
